// File: rtl/shift_spill_unit_if.sv
// Start/operand/result bundle for the shift-spill unit.
// master drives the request side; slave is the unit itself.
interface shift_spill_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Out;
    logic [WIDTH-1:0] Spill;

    modport master (
        output Start,
        output In1,
        output In2,
        input  Ready,
        input  Done,
        input  Out,
        input  Spill
    );

    modport slave (
        input  Start,
        input  In1,
        input  In2,
        output Ready,
        output Done,
        output Out,
        output Spill
    );
endinterface

// File: rtl/shift_spill_unit.sv
// Bit-serial shifter that keeps the shifted-out bits in Spill.
// Define SHIFT_SPILL_ARITH_EN for sign fill on right shifts (In2[30]).
module shift_spill_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    shift_spill_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   spill_q, spill_d;
    logic               dir_q, dir_d;
    logic               fill;
    logic [AMT_W-1:0]   amt;

`ifdef SHIFT_SPILL_ARITH_EN
    logic               sign_q, sign_d;
    assign fill = sign_q;
`else
    assign fill = 1'b0;
`endif

    assign amt = bus.In2[AMT_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        spill_d = spill_q;
        dir_d   = dir_q;
`ifdef SHIFT_SPILL_ARITH_EN
        sign_d  = sign_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    out_d   = bus.In1;
                    spill_d = '0;
                    dir_d   = bus.In2[WIDTH-1];
                    cnt_d   = amt;
`ifdef SHIFT_SPILL_ARITH_EN
                    // Fill bit is fixed at Start; Out's MSB changes while shifting.
                    sign_d  = bus.In2[WIDTH-2] & bus.In1[WIDTH-1];
`endif
                    state_d = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (dir_q) begin
                    spill_d = {spill_q[WIDTH-2:0], out_q[WIDTH-1]};
                    out_d   = {out_q[WIDTH-2:0], 1'b0};
                end else begin
                    spill_d = {out_q[0], spill_q[WIDTH-1:1]};
                    out_d   = {fill, out_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            spill_q <= '0;
            dir_q   <= 1'b0;
`ifdef SHIFT_SPILL_ARITH_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            spill_q <= spill_d;
            dir_q   <= dir_d;
`ifdef SHIFT_SPILL_ARITH_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign bus.Ready = (state_q == IDLE);
    assign bus.Done  = (state_q == DONE);
    assign bus.Out   = out_q;
    assign bus.Spill = spill_q;
endmodule

// File: tb/tb_shift_spill_unit.sv
// Directed vector bench for shift_spill_unit.
// Build with SHIFT_SPILL_ARITH_EN to check the sign-fill variant.
module tb_shift_spill_unit;
    logic clk;
    logic rst_n;

    shift_spill_unit_if #(.WIDTH(32)) bus ();

    shift_spill_unit #(
        .WIDTH (32),
        .AMT_W (5)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] exp_out;
        logic [31:0] exp_spill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp;
    int   n_err;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.In1   = a;
        bus.In2   = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Returns how many negedges after the Start edge Done was first seen.
    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.Done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        check({v.name, "_ready_before"}, 32'(bus.Ready), 32'd1);
        pulse_start(v.in1, v.in2);
        wait_done(lat, got);
        check({v.name, "_done_seen"}, 32'(got), 32'd1);
        check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, "_out"}, bus.Out, v.exp_out);
        check({v.name, "_spill"}, bus.Spill, v.exp_spill);
        @(negedge clk);
        check({v.name, "_done_1cyc"}, 32'(bus.Done), 32'd0);
        check({v.name, "_ready_after"}, 32'(bus.Ready), 32'd1);
        check({v.name, "_out_hold"}, bus.Out, v.exp_out);
    endtask

    initial begin
        int lat;
        bit got;
        int seen;
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{"left4", 32'hF000_000F, 32'h8000_0004,
                    32'h0000_00F0, 32'h0000_000F, 5};
        vecs[1] = '{"right8", 32'h1234_5678, 32'h0000_0008,
                    32'h0012_3456, 32'h7800_0000, 9};
        vecs[2] = '{"zero_amt", 32'hDEAD_BEEF, 32'h8000_0000,
                    32'hDEAD_BEEF, 32'h0000_0000, 1};
        vecs[3] = '{"left31", 32'h8000_0001, 32'h8000_001F,
                    32'h8000_0000, 32'h4000_0000, 32};
        vecs[4] = '{"right1", 32'h8000_0001, 32'h0000_0001,
                    32'h4000_0000, 32'h8000_0000, 2};
        vecs[5] = '{"right16", 32'hA5A5_A5A5, 32'h0000_0010,
                    32'h0000_A5A5, 32'hA5A5_0000, 17};
        vecs[6] = '{"ign_bits", 32'hE000_0001, 32'h9FFF_FFE3,
                    32'h0000_0008, 32'h0000_0007, 4};
`ifdef SHIFT_SPILL_ARITH_EN
        vecs[7] = '{"arith_neg", 32'h8000_0010, 32'h4000_0004,
                    32'hF800_0001, 32'h0000_0000, 5};
`else
        vecs[7] = '{"arith_neg", 32'h8000_0010, 32'h4000_0004,
                    32'h0800_0001, 32'h0000_0000, 5};
`endif
        vecs[8] = '{"arith_pos", 32'h4000_0010, 32'h4000_0004,
                    32'h0400_0001, 32'h0000_0000, 5};

        bus.Start = 1'b0;
        bus.In1   = '0;
        bus.In2   = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.Ready), 32'd1);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_out", bus.Out, 32'h0);
        check("rst_spill", bus.Spill, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Start during DONE must be dropped.
        pulse_start(32'hDEAD_BEEF, 32'h8000_0000);
        @(negedge clk);
        check("ovl_done", 32'(bus.Done), 32'd1);
        bus.Start = 1'b1;
        bus.In1   = 32'h1111_1111;
        bus.In2   = 32'h8000_0004;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        @(negedge clk);
        check("ovl_ready", 32'(bus.Ready), 32'd1);
        check("ovl_out", bus.Out, 32'hDEAD_BEEF);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.Done === 1'b1) seen++;
        end
        check("ovl_no_done", 32'(seen), 32'd0);

        // Start during SHIFT must not disturb the running shift.
        pulse_start(32'hF000_000F, 32'h8000_0004);
        @(negedge clk);
        check("busy_ready", 32'(bus.Ready), 32'd0);
        bus.Start = 1'b1;
        bus.In1   = 32'h5555_5555;
        bus.In2   = 32'h0000_0002;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_done(lat, got);
        check("busy_done_seen", 32'(got), 32'd1);
        check("busy_lat", 32'(lat + 1), 32'd5);
        check("busy_out", bus.Out, 32'h0000_00F0);
        check("busy_spill", bus.Spill, 32'h0000_000F);
        @(negedge clk);

        // Reset in the middle of a 31-bit shift.
        pulse_start(32'hCAFE_F00D, 32'h0000_001F);
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus.Done === 1'b1) seen++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.Ready), 32'd1);
        check("mid_rst_out", bus.Out, 32'h0);
        check("mid_rst_spill", bus.Spill, 32'h0);
        repeat (35) begin
            @(negedge clk);
            if (bus.Done === 1'b1) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
